// File: rtl/layer_pingpong_control.sv
// Ping-pong controller between a producer and a consumer layer: sequences both
// layers through two feature RAM banks and muxes each bank to its current owner.
module layer_pingpong_control #(
   parameter int ADDR_WIDTH = 9,
   parameter int Q_WIDTH    = 64,
   parameter int NUM_FRAMES = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  all_done,
   output logic                  prod_enable,
   output logic                  prod_reset,
   input  logic                  prod_done,
   output logic                  cons_enable,
   output logic                  cons_reset,
   input  logic                  cons_done,
   input  logic [ADDR_WIDTH-1:0] prod_addr_a,
   input  logic [ADDR_WIDTH-1:0] prod_addr_b,
   input  logic                  prod_wren_a,
   input  logic                  prod_wren_b,
   input  logic [ADDR_WIDTH-1:0] cons_addr_a,
   input  logic [ADDR_WIDTH-1:0] cons_addr_b,
   input  logic                  cons_rden_a,
   input  logic                  cons_rden_b,
   output logic [Q_WIDTH-1:0]    cons_q_a,
   output logic [Q_WIDTH-1:0]    cons_q_b,
   output logic [ADDR_WIDTH-1:0] bank0_addr_a,
   output logic [ADDR_WIDTH-1:0] bank0_addr_b,
   output logic                  bank0_rden_a,
   output logic                  bank0_rden_b,
   output logic                  bank0_wren_a,
   output logic                  bank0_wren_b,
   input  logic [Q_WIDTH-1:0]    bank0_q_a,
   input  logic [Q_WIDTH-1:0]    bank0_q_b,
   output logic [ADDR_WIDTH-1:0] bank1_addr_a,
   output logic [ADDR_WIDTH-1:0] bank1_addr_b,
   output logic                  bank1_rden_a,
   output logic                  bank1_rden_b,
   output logic                  bank1_wren_a,
   output logic                  bank1_wren_b,
   input  logic [Q_WIDTH-1:0]    bank1_q_a,
   input  logic [Q_WIDTH-1:0]    bank1_q_b,
   output logic                  prod_bank,
   output logic                  cons_bank,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   localparam logic [2:0] P_IDLE = 3'd0;
   localparam logic [2:0] P_CLR  = 3'd1;
   localparam logic [2:0] P_RUN  = 3'd2;
   localparam logic [2:0] P_WAIT = 3'd3;
   localparam logic [2:0] P_FIN  = 3'd4;

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_CLR  = 2'd1;
   localparam logic [1:0] C_RUN  = 2'd2;
   localparam logic [1:0] C_FIN  = 2'd3;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_FRAMES);

   logic [2:0]           p_state_q, p_state_d;
   logic [1:0]           c_state_q, c_state_d;
   logic [1:0]           full_q, full_d;
   logic                 prod_bank_q, prod_bank_d;
   logic                 cons_bank_q, cons_bank_d;
   logic [CNT_WIDTH-1:0] prod_cnt_q, prod_cnt_d;
   logic [CNT_WIDTH-1:0] cons_cnt_q, cons_cnt_d;
   logic                 set_full, clr_full;

   assign set_full = enable && (p_state_q == P_RUN) && prod_done;
   assign clr_full = enable && (c_state_q == C_RUN) && cons_done;

   always_comb begin
      p_state_d   = p_state_q;
      c_state_d   = c_state_q;
      full_d      = full_q;
      prod_bank_d = prod_bank_q;
      cons_bank_d = cons_bank_q;
      prod_cnt_d  = prod_cnt_q;
      cons_cnt_d  = cons_cnt_q;
      if (!enable) begin
         // Abort: everything returns to its power-on state, restart is from bank 0
         p_state_d   = P_IDLE;
         c_state_d   = C_IDLE;
         full_d      = '0;
         prod_bank_d = 1'b0;
         cons_bank_d = 1'b0;
         prod_cnt_d  = '0;
         cons_cnt_d  = '0;
      end else begin
         case (p_state_q)
            P_IDLE: p_state_d = P_CLR;
            P_CLR:  p_state_d = P_RUN;
            P_RUN: begin
               if (prod_done) begin
                  prod_bank_d = ~prod_bank_q;
                  prod_cnt_d  = prod_cnt_q + CNT_WIDTH'(1);
                  p_state_d   = (prod_cnt_q + CNT_WIDTH'(1) == LAST_CNT) ? P_FIN : P_WAIT;
               end
            end
            P_WAIT: if (!full_q[prod_bank_q]) p_state_d = P_CLR;
            P_FIN:  p_state_d = P_FIN;
            default: p_state_d = P_IDLE;
         endcase

         case (c_state_q)
            C_IDLE: if (full_q[cons_bank_q]) c_state_d = C_CLR;
            C_CLR:  c_state_d = C_RUN;
            C_RUN: begin
               if (cons_done) begin
                  cons_bank_d = ~cons_bank_q;
                  cons_cnt_d  = cons_cnt_q + CNT_WIDTH'(1);
                  c_state_d   = (cons_cnt_q + CNT_WIDTH'(1) == LAST_CNT) ? C_FIN : C_IDLE;
               end
            end
            default: c_state_d = C_FIN;
         endcase

         if (set_full) full_d[prod_bank_q] = 1'b1;
         if (clr_full) full_d[cons_bank_q] = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_state_q   <= P_IDLE;
         c_state_q   <= C_IDLE;
         full_q      <= '0;
         prod_bank_q <= 1'b0;
         cons_bank_q <= 1'b0;
         prod_cnt_q  <= '0;
         cons_cnt_q  <= '0;
      end else begin
         p_state_q   <= p_state_d;
         c_state_q   <= c_state_d;
         full_q      <= full_d;
         prod_bank_q <= prod_bank_d;
         cons_bank_q <= cons_bank_d;
         prod_cnt_q  <= prod_cnt_d;
         cons_cnt_q  <= cons_cnt_d;
      end
   end

   assert property (@(posedge clock) disable iff (!reset)
      !(set_full && clr_full && (prod_bank_q == cons_bank_q)));

   assign prod_reset  = (p_state_q == P_CLR);
   assign prod_enable = (p_state_q == P_RUN);
   assign cons_reset  = (c_state_q == C_CLR);
   assign cons_enable = (c_state_q == C_RUN);
   assign all_done    = (c_state_q == C_FIN);
   assign prod_bank   = prod_bank_q;
   assign cons_bank   = cons_bank_q;
   assign frame_count = cons_cnt_q;
   assign cons_q_a    = cons_bank_q ? bank1_q_a : bank0_q_a;
   assign cons_q_b    = cons_bank_q ? bank1_q_b : bank0_q_b;

   // Producer ownership wins; the consumer only ever holds the other bank
   always_comb begin
      bank0_addr_a = '0;
      bank0_addr_b = '0;
      bank0_rden_a = 1'b0;
      bank0_rden_b = 1'b0;
      bank0_wren_a = 1'b0;
      bank0_wren_b = 1'b0;
      bank1_addr_a = '0;
      bank1_addr_b = '0;
      bank1_rden_a = 1'b0;
      bank1_rden_b = 1'b0;
      bank1_wren_a = 1'b0;
      bank1_wren_b = 1'b0;
      if (prod_enable && !prod_bank_q) begin
         bank0_addr_a = prod_addr_a;
         bank0_addr_b = prod_addr_b;
         bank0_wren_a = prod_wren_a;
         bank0_wren_b = prod_wren_b;
      end else if (cons_enable && !cons_bank_q) begin
         bank0_addr_a = cons_addr_a;
         bank0_addr_b = cons_addr_b;
         bank0_rden_a = cons_rden_a;
         bank0_rden_b = cons_rden_b;
      end
      if (prod_enable && prod_bank_q) begin
         bank1_addr_a = prod_addr_a;
         bank1_addr_b = prod_addr_b;
         bank1_wren_a = prod_wren_a;
         bank1_wren_b = prod_wren_b;
      end else if (cons_enable && cons_bank_q) begin
         bank1_addr_a = cons_addr_a;
         bank1_addr_b = cons_addr_b;
         bank1_rden_a = cons_rden_a;
         bank1_rden_b = cons_rden_b;
      end
   end

endmodule

// File: tb/tb_layer_pingpong_control.sv
// Bench for layer_pingpong_control: emulated layers with random frame lengths,
// checked cycle by cycle against a frame-schedule model of the ping-pong pipeline.
module tb_layer_pingpong_control;

   localparam int AW = 9;
   localparam int QW = 64;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    en = '0;
   logic          prod_done = 1'b0, cons_done = 1'b0;
   logic [AW-1:0] prod_addr_a = '0, prod_addr_b = '0, cons_addr_a = '0, cons_addr_b = '0;
   logic          prod_wren_a = 1'b0, prod_wren_b = 1'b0, cons_rden_a = 1'b0, cons_rden_b = 1'b0;
   logic [QW-1:0] bank0_q_a = '0, bank0_q_b = '0, bank1_q_a = '0, bank1_q_b = '0;

   logic [1:0] all_done_w, prod_enable_w, prod_reset_w, cons_enable_w, cons_reset_w;
   logic [1:0] prod_bank_w, cons_bank_w;
   logic [1:0] b0_rden_a_w, b0_rden_b_w, b0_wren_a_w, b0_wren_b_w;
   logic [1:0] b1_rden_a_w, b1_rden_b_w, b1_wren_a_w, b1_wren_b_w;
   logic [1:0][AW-1:0] b0_addr_a_w, b0_addr_b_w, b1_addr_a_w, b1_addr_b_w;
   logic [1:0][QW-1:0] cons_q_a_w, cons_q_b_w;
   logic [1:0][CW-1:0] frame_count_w;

   int checks = 0;
   int errors = 0;
   int lp[8], lc[8];
   int P[8], D[8], C[8], CD[8];

   always #5 clock = ~clock;

   // Instance 0 runs four frames, instance 1 a single frame
   for (genvar g = 0; g < 2; g++) begin : g_dut
      layer_pingpong_control #(
         .ADDR_WIDTH(AW), .Q_WIDTH(QW), .NUM_FRAMES((g == 0) ? 4 : 1), .CNT_WIDTH(CW)
      ) u_dut (
         .clock(clock), .reset(reset), .enable(en[g]), .all_done(all_done_w[g]),
         .prod_enable(prod_enable_w[g]), .prod_reset(prod_reset_w[g]), .prod_done(prod_done),
         .cons_enable(cons_enable_w[g]), .cons_reset(cons_reset_w[g]), .cons_done(cons_done),
         .prod_addr_a(prod_addr_a), .prod_addr_b(prod_addr_b),
         .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
         .cons_addr_a(cons_addr_a), .cons_addr_b(cons_addr_b),
         .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b),
         .cons_q_a(cons_q_a_w[g]), .cons_q_b(cons_q_b_w[g]),
         .bank0_addr_a(b0_addr_a_w[g]), .bank0_addr_b(b0_addr_b_w[g]),
         .bank0_rden_a(b0_rden_a_w[g]), .bank0_rden_b(b0_rden_b_w[g]),
         .bank0_wren_a(b0_wren_a_w[g]), .bank0_wren_b(b0_wren_b_w[g]),
         .bank0_q_a(bank0_q_a), .bank0_q_b(bank0_q_b),
         .bank1_addr_a(b1_addr_a_w[g]), .bank1_addr_b(b1_addr_b_w[g]),
         .bank1_rden_a(b1_rden_a_w[g]), .bank1_rden_b(b1_rden_b_w[g]),
         .bank1_wren_a(b1_wren_a_w[g]), .bank1_wren_b(b1_wren_b_w[g]),
         .bank1_q_a(bank1_q_a), .bank1_q_b(bank1_q_b),
         .prod_bank(prod_bank_w[g]), .cons_bank(cons_bank_w[g]),
         .frame_count(frame_count_w[g])
      );
   end

   function automatic logic [6:0] got_ctrl(input int s);
      return {prod_reset_w[s], prod_enable_w[s], cons_reset_w[s], cons_enable_w[s],
              prod_bank_w[s], cons_bank_w[s], all_done_w[s]};
   endfunction

   function automatic logic [43:0] got_mux(input int s);
      return {b0_addr_a_w[s], b0_addr_b_w[s], b0_rden_a_w[s], b0_rden_b_w[s],
              b0_wren_a_w[s], b0_wren_b_w[s],
              b1_addr_a_w[s], b1_addr_b_w[s], b1_rden_a_w[s], b1_rden_b_w[s],
              b1_wren_a_w[s], b1_wren_b_w[s]};
   endfunction

   // Frame schedule (cycle numbers, enable raised in cycle 0): a bank becomes
   // free for the next user the cycle after the previous user's done is seen.
   task automatic compute_model(input int nf);
      int avail;
      P[0] = 1;
      for (int k = 0; k < nf; k++) begin
         D[k] = P[k] + 1 + lp[k];
         avail = D[k] + 1;
         if (k > 0 && CD[k-1] + 1 > avail) avail = CD[k-1] + 1;
         C[k] = avail + 1;
         CD[k] = C[k] + 1 + lc[k];
         if (k + 1 < nf) P[k+1] = avail + 1;
      end
   endtask

   // kind 0: full run then enable low; 1: enable low mid producer frame 2;
   // 2: async reset mid consumer frame 1
   task automatic run_frames(input int s, input int kind);
      int nf, last, pf, cf, pcnt, ccnt, plat, clat, nd, ncd;
      bit pdone, cdone, ppres, ppen, pcres, pcen;
      bit e_pres, e_pen, e_cres, e_cen, e_pb, e_cb, e_done;
      logic [6:0]  exp_ctrl;
      logic [21:0] eb0, eb1;
      logic [43:0] exp_mux;
      logic [QW-1:0] exp_qa, exp_qb;
      string nm;
      nf = (s == 0) ? 4 : 1;
      compute_model(nf);
      last = (kind == 1) ? P[1] + 3 : (kind == 2) ? C[0] + 3 : CD[nf-1] + 4;
      pf = 0; cf = 0; pcnt = 0; ccnt = 0; plat = 1; clat = 1;
      pdone = 0; cdone = 0; ppres = 0; ppen = 0; pcres = 0; pcen = 0;
      en[s] = 1'b1;
      for (int c = 0; c <= last; c++) begin
         if (c > 0) begin @(posedge clock); #1; end
         if (ppres) begin pcnt = 0; pdone = 0; plat = lp[pf]; pf++; end
         else if (ppen && !pdone) begin pcnt++; if (pcnt == plat) pdone = 1; end
         if (pcres) begin ccnt = 0; cdone = 0; clat = lc[cf]; cf++; end
         else if (pcen && !cdone) begin ccnt++; if (ccnt == clat) cdone = 1; end
         prod_done = pdone;
         cons_done = cdone;
         prod_addr_a = AW'($urandom); prod_addr_b = AW'($urandom);
         cons_addr_a = AW'($urandom); cons_addr_b = AW'($urandom);
         {prod_wren_a, prod_wren_b, cons_rden_a, cons_rden_b} = 4'($urandom);
         bank0_q_a = {$urandom, $urandom}; bank0_q_b = {$urandom, $urandom};
         bank1_q_a = {$urandom, $urandom}; bank1_q_b = {$urandom, $urandom};
         if (kind == 0 && s == 0 && lp[0] == 10 && lc[0] == 10) begin
            prod_addr_a = 9'h1A5; prod_wren_a = 1'b1;
            cons_addr_a = 9'h003; cons_rden_a = 1'b1;
         end
         #1;
         e_pres = 0; e_pen = 0; e_cres = 0; e_cen = 0; nd = 0; ncd = 0;
         for (int k = 0; k < nf; k++) begin
            if (c == P[k]) e_pres = 1;
            if (c > P[k] && c <= D[k]) e_pen = 1;
            if (c == C[k]) e_cres = 1;
            if (c > C[k] && c <= CD[k]) e_cen = 1;
            if (D[k] < c) nd++;
            if (CD[k] < c) ncd++;
         end
         e_pb = nd[0]; e_cb = ncd[0]; e_done = (ncd == nf);
         exp_ctrl = {e_pres, e_pen, e_cres, e_cen, e_pb, e_cb, e_done};
         eb0 = '0; eb1 = '0;
         if (e_pen && !e_pb)      eb0 = {prod_addr_a, prod_addr_b, 2'b00, prod_wren_a, prod_wren_b};
         else if (e_cen && !e_cb) eb0 = {cons_addr_a, cons_addr_b, cons_rden_a, cons_rden_b, 2'b00};
         if (e_pen && e_pb)       eb1 = {prod_addr_a, prod_addr_b, 2'b00, prod_wren_a, prod_wren_b};
         else if (e_cen && e_cb)  eb1 = {cons_addr_a, cons_addr_b, cons_rden_a, cons_rden_b, 2'b00};
         exp_mux = {eb0, eb1};
         exp_qa = e_cb ? bank1_q_a : bank0_q_a;
         exp_qb = e_cb ? bank1_q_b : bank0_q_b;
         checks++;
         if (got_ctrl(s) !== exp_ctrl) begin
            errors++;
            $display("FAIL ctrl s=%0d c=%0d got=%b exp=%b (pres,pen,cres,cen,pbank,cbank,done)",
                     s, c, got_ctrl(s), exp_ctrl);
         end
         checks++;
         if (frame_count_w[s] !== CW'(ncd)) begin
            errors++;
            $display("FAIL frame_count s=%0d c=%0d got=%0d exp=%0d", s, c, frame_count_w[s], ncd);
         end
         checks++;
         if (got_mux(s) !== exp_mux) begin
            errors++;
            $display("FAIL mux s=%0d c=%0d got=%h exp=%h", s, c, got_mux(s), exp_mux);
         end
         checks++;
         if (cons_q_a_w[s] !== exp_qa || cons_q_b_w[s] !== exp_qb) begin
            errors++;
            $display("FAIL cons_q s=%0d c=%0d got=%h/%h exp=%h/%h",
                     s, c, cons_q_a_w[s], cons_q_b_w[s], exp_qa, exp_qb);
         end
         ppres = prod_reset_w[s]; ppen = prod_enable_w[s];
         pcres = cons_reset_w[s]; pcen = cons_enable_w[s];
      end
      if (kind == 2) begin
         nm = "async_reset";
         #2 reset = 1'b0;
         #1;
      end else begin
         nm = (kind == 1) ? "abort" : "stop";
         en[s] = 1'b0;
         @(posedge clock); #2;
      end
      checks++;
      if (got_ctrl(s) !== 7'd0 || frame_count_w[s] !== '0 || got_mux(s) !== 44'd0) begin
         errors++;
         $display("FAIL %s s=%0d got ctrl=%b fc=%0d mux=%h exp all zero",
                  nm, s, got_ctrl(s), frame_count_w[s], got_mux(s));
      end
      prod_done = 1'b0;
      cons_done = 1'b0;
      if (kind != 2) begin @(posedge clock); #1; end
   endtask

   task automatic set_lat(input int p, input int q);
      for (int k = 0; k < 8; k++) begin lp[k] = p; lc[k] = q; end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1 en[0] = 1'b1;
      #1;
      checks++;
      if (got_ctrl(0) !== 7'd0 || frame_count_w[0] !== '0 || got_mux(0) !== 44'd0) begin
         errors++;
         $display("FAIL reset got ctrl=%b fc=%0d mux=%h exp all zero",
                  got_ctrl(0), frame_count_w[0], got_mux(0));
      end
      en[0] = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (got_ctrl(0) !== 7'd0 || got_ctrl(1) !== 7'd0) begin
         errors++;
         $display("FAIL idle got ctrl0=%b ctrl1=%b exp 0", got_ctrl(0), got_ctrl(1));
      end
   endtask

   task automatic test_basic;
      set_lat(10, 10);
      run_frames(0, 0);
   endtask

   task automatic test_slow_consumer;
      set_lat(10, 50);
      run_frames(0, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 8; k++) begin
            lp[k] = int'($urandom_range(1, 20));
            lc[k] = int'($urandom_range(1, 20));
         end
         run_frames(0, 0);
      end
   endtask

   task automatic test_abort;
      set_lat(10, 10);
      run_frames(0, 1);
      set_lat(7, 12);
      run_frames(0, 0);
   endtask

   task automatic test_async_reset;
      set_lat(10, 10);
      run_frames(0, 2);
      @(posedge clock); #1 reset = 1'b1;
      set_lat(9, 4);
      run_frames(0, 0);
   endtask

   task automatic test_single_frame;
      set_lat(10, 10);
      run_frames(1, 0);
      lp[0] = int'($urandom_range(1, 20));
      lc[0] = int'($urandom_range(1, 20));
      run_frames(1, 0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_slow_consumer;
      test_random;
      test_abort;
      test_async_reset;
      test_single_frame;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout exp finish before 2000000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/layer_pingpong_control.md
Name: layer_pingpong_control

Overview:
- Sequences one producer layer (conv/pool) and one consumer layer through a two-bank ping-pong inter-layer feature RAM.
- Overlaps producer frame N+1 with consumer frame N.
- Owns bank full/empty bookkeeping, the per-layer enable/reset sequencing and the address/enable muxing into both RAM banks.
- Sits between layer_N and layer_N+1, in place of a single-buffer inter-layer control.

Parameters:
- ADDR_WIDTH, 9, feature RAM address width per bank.
- Q_WIDTH, 64, RAM read-data width per port (DATA_WIDTH*NUM_MULT).
- NUM_FRAMES, 4, frames processed per run (>=1).
- CNT_WIDTH, 8, width of frame counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values.
- enable  in  1  run request (level); 1 starts/continues a run, 0 aborts/idles.
- all_done  out  1  high after last frame consumed, held until enable=0.
- prod_enable  out  1  producer layer enable.
- prod_reset  out  1  producer layer clear, active-high, 1-cycle pulse.
- prod_done  in  1  producer frame complete (level, cleared by prod_reset).
- cons_enable  out  1  consumer layer enable.
- cons_reset  out  1  consumer layer clear, active-high, 1-cycle pulse.
- cons_done  in  1  consumer frame complete (level, cleared by cons_reset).
- prod_addr_a, prod_addr_b  in  ADDR_WIDTH  producer write addresses.
- prod_wren_a, prod_wren_b  in  1  producer write enables.
- cons_addr_a, cons_addr_b  in  ADDR_WIDTH  consumer read addresses.
- cons_rden_a, cons_rden_b  in  1  consumer read enables.
- cons_q_a, cons_q_b  out  Q_WIDTH  read data from consumer's bank.
- bankN_addr_a, bankN_addr_b  out  ADDR_WIDTH  (N=0,1) bank RAM addresses.
- bankN_rden_a, bankN_rden_b, bankN_wren_a, bankN_wren_b  out  1  bank RAM enables.
- bankN_q_a, bankN_q_b  in  Q_WIDTH  bank RAM read data.
- prod_bank, cons_bank  out  1  bank currently assigned to producer/consumer.
- frame_count  out  CNT_WIDTH  frames consumed so far.

Behaviour:
- Reset values: all outputs 0; full[1:0]=0; prod_cnt=cons_cnt=0; FSMs in IDLE.
- Producer FSM P_IDLE/P_CLR/P_RUN/P_WAIT/P_FIN:
  - P_IDLE: enable=1 -> P_CLR.
  - P_CLR: prod_reset=1 for exactly this cycle -> P_RUN.
  - P_RUN: prod_enable=1. On prod_done=1: set full[prod_bank], toggle prod_bank, prod_cnt+1, prod_enable=0 next cycle. If prod_cnt+1==NUM_FRAMES -> P_FIN, else -> P_WAIT.
  - P_WAIT: full[prod_bank]==0 -> P_CLR; otherwise stall.
  - P_FIN: idle until enable=0.
- Consumer FSM C_IDLE/C_CLR/C_RUN/C_FIN:
  - C_IDLE: full[cons_bank]==1 and enable=1 -> C_CLR.
  - C_CLR: cons_reset=1 for one cycle -> C_RUN.
  - C_RUN: cons_enable=1. On cons_done=1: clear full[cons_bank], toggle cons_bank, cons_cnt+1. If cons_cnt+1==NUM_FRAMES -> C_FIN with all_done=1, else -> C_IDLE.
- Latencies:
  - enable rise -> prod_reset 1 cycle later -> prod_enable the following cycle.
  - prod_done -> consumer cons_reset 2 cycles later when consumer is idle.
- prod_done/cons_done outside RUN are ignored.
- Set/clear of full in the same cycle always target different banks (invariant); both apply. A set and clear on the same bank is unreachable; assert this in simulation.
- Mux (combinational):
  - bank B takes producer addr/wren when prod_enable && prod_bank==B. Its rden is 0.
  - Otherwise bank B takes consumer addr/rden when cons_enable && cons_bank==B. Its wren is 0.
  - Otherwise all bank B outputs are 0.
  - cons_q_* = cons_bank ? bank1_q_* : bank0_q_*. No added read latency.
- frame_count = cons_cnt. prod_bank/cons_bank are registered.
- enable=0 mid-run: next cycle both FSMs go to IDLE, full cleared, counters 0, all enables/all_done 0, no reset pulses. enable=1 later restarts from bank 0.
- Async reset mid-run: immediate return to reset values, no glitch pulse on *_reset.

Test Plan:
- NUM_FRAMES=4, prod_done after 10 cycles, cons_done after 10 cycles:
  - Banks alternate 0,1,0,1.
  - Consumer frame k overlaps producer frame k+1.
  - all_done rises exactly once; frame_count=4.
- Slow consumer (cons_done 50 cycles, prod 10):
  - Producer stalls in P_WAIT with prod_enable=0 while both full bits =1.
  - Producer resumes 2 cycles after consumer clears its bank.
- Mux check:
  - Producer drives addr 0x1A5 wren_a=1 on bank0 while consumer reads bank1 addr 0x003.
  - bank0_addr_a=0x1A5, bank0_wren_a=1, bank1_addr_a=0x003, bank1_wren_*=0, cons_q_a=bank1_q_a.
- Abort: enable=0 during second producer frame -> next cycle all enables 0, full=00, frame_count=0. Re-enable -> prod_reset pulse, prod_bank=0.
- Async reset low mid-C_RUN -> all outputs 0 immediately. After release with enable=1 -> normal start sequence.
- NUM_FRAMES=1 -> single producer and consumer pass on bank 0 only, all_done=1, bank1 enables never asserted.
